// File: rtl/jk_excite_pkg.sv
// Shared types and constants for the JK excitation controller.
package jk_excite_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    WAIT  = 2'd2,
    CHECK = 2'd3
  } state_t;

  // Per-bit excitation codes, packed as {J,K}
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Width of the settle and retry counters (SETTLE, MAX_RETRY <= 15)
  localparam int CNT_W = 4;

endpackage

// File: rtl/jk_excite_ctrl_if.sv
// Bus between the register-programming side, the controller and the JK bank.
interface jk_excite_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             tgt_valid;
  logic             tgt_ready;
  logic [WIDTH-1:0] tgt_data;
  logic [WIDTH-1:0] tgt_mask;
  logic [WIDTH-1:0] Q_fb;
  logic [WIDTH-1:0] J;
  logic [WIDTH-1:0] K;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] err_bits;

  // Controller side
  modport slave (
    input  tgt_valid, tgt_data, tgt_mask, Q_fb,
    output tgt_ready, J, K, busy, done, err, err_bits
  );

  // Programming logic / bank side
  modport master (
    output tgt_valid, tgt_data, tgt_mask, Q_fb,
    input  tgt_ready, J, K, busy, done, err, err_bits
  );

endinterface

// File: rtl/jk_excite_enc.sv
// Combinational per-word J/K encoder.
// Build option JK_TOGGLE_EN: bank toggles on J=K=1, so every differing bit
// is driven with the toggle code instead of a directional set/clear.
module jk_excite_enc
  import jk_excite_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] tgt_i,
  input  logic [WIDTH-1:0] mask_i,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o
);

  logic [WIDTH-1:0] diff;

  function automatic logic [1:0] enc_bit(input logic d, input logic t);
    logic [1:0] code;
    if (!d) begin
      code = JK_HOLD;
    end else begin
`ifdef JK_TOGGLE_EN
      code = JK_TGL;
`else
      code = t ? JK_SET : JK_CLR;
`endif
    end
    return code;
  endfunction

  // Map each masked differing bit to its excitation code
  always_comb begin
    logic [1:0] code;
    diff = mask_i & (tgt_i ^ q_i);
    j_o  = '0;
    k_o  = '0;
    code = JK_HOLD;
    for (int i = 0; i < WIDTH; i++) begin
      code   = enc_bit(diff[i], tgt_i[i]);
      j_o[i] = code[1];
      k_o[i] = code[0];
    end
  end

endmodule

// File: rtl/jk_excite_ctrl.sv
// JK excitation controller: accept target/mask, pulse J/K for one cycle,
// settle, verify Q_fb, retry up to MAX_RETRY times, then report done/err.
// Optional build macro: JK_TOGGLE_EN (toggle-style excitation in the encoder).
module jk_excite_ctrl
  import jk_excite_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SETTLE    = 1,
  parameter int MAX_RETRY = 3
) (
  input  logic          CLK,
  input  logic          RESET,
  jk_excite_ctrl_if.slave bus
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] retry_q, retry_d;
  logic [WIDTH-1:0] tgt_q, mask_q;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic [WIDTH-1:0] errb_q, errb_d;
  logic             done_q, done_d, err_q, err_d;
  logic             accept;
  logic [WIDTH-1:0] enc_tgt, enc_mask, enc_j, enc_k, mm;

  assign accept   = bus.tgt_valid && (state_q == IDLE);
  // In IDLE the encoder sees the incoming word; on retries, the latched word
  assign enc_tgt  = (state_q == IDLE) ? bus.tgt_data : tgt_q;
  assign enc_mask = (state_q == IDLE) ? bus.tgt_mask : mask_q;
  assign mm       = mask_q & (tgt_q ^ bus.Q_fb);

  jk_excite_enc #(.WIDTH(WIDTH)) u_enc (
    .tgt_i  (enc_tgt),
    .mask_i (enc_mask),
    .q_i    (bus.Q_fb),
    .j_o    (enc_j),
    .k_o    (enc_k)
  );

  // Next-state, drive and status logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    j_d     = '0;
    k_d     = '0;
    errb_d  = errb_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = DRIVE;
          j_d     = enc_j;
          k_d     = enc_k;
          retry_d = '0;
          cnt_d   = '0;
          errb_d  = '0;
        end
      end
      DRIVE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // WAIT spans SETTLE+1 cycles so done lands 3+SETTLE edges after accept
        if (cnt_q == CNT_W'(SETTLE)) state_d = CHECK;
        else                         cnt_d   = cnt_q + 1'b1;
      end
      CHECK: begin
        if (mm == '0) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (retry_q < CNT_W'(MAX_RETRY)) begin
          retry_d = retry_q + 1'b1;
          state_d = DRIVE;
          j_d     = enc_j;
          k_d     = enc_k;
        end else begin
          err_d   = 1'b1;
          errb_d  = mm;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers; reset drops J/K immediately
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
      j_q     <= '0;
      k_q     <= '0;
      errb_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      j_q     <= j_d;
      k_q     <= k_d;
      errb_q  <= errb_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Target word capture; later changes on the inputs are ignored while busy
  always_ff @(posedge CLK) begin
    if (accept) begin
      tgt_q  <= bus.tgt_data;
      mask_q <= bus.tgt_mask;
    end
  end

  assign bus.tgt_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.J         = j_q;
  assign bus.K         = k_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_bits  = errb_q;

endmodule
